btn_step_ctrl: RTL and testbench
================================

// Module: btn_step_ctrl
//
// PURPOSE
// - Conditions the two raw frequency-step push-buttons (up/down) into clean single-cycle step pulses.
// - Feeds freq_up_i/freq_dwn_i of the tick freq_gen in fpga_top.
// - Per-button processing: polarity fix, synchronizer, press/release debounce, conflict rejection.
// - Optional hold-to-repeat stepping.
//
// PARAMETERS
// - NUM_SYNC       2      synchronizer flops per button, >=2
// - DEBOUNCE       50000  consecutive stable cycles required to accept a press or release, >=1
// - BTN_ACTIVE     1      1: buttons active-high; 0: active-low (inverted before the synchronizer)
// - REPEAT_DELAY   25000000  held cycles before the first auto-repeat pulse, >=1 (_EN builds only)
// - REPEAT_PERIOD  5000000   cycles between subsequent auto-repeat pulses, >=1 (_EN builds only)
//
// PORTS
// - clk_i        in   1  system clock
// - arstn_i      in   1  asynchronous active-low reset
// - up_btn_i     in   1  raw freq-up button, asynchronous to clk_i
// - dwn_btn_i    in   1  raw freq-down button, asynchronous to clk_i
// - up_pulse_o   out  1  one-cycle freq-up step, registered
// - dwn_pulse_o  out  1  one-cycle freq-down step, registered
// - held_o       out  1  1 while state != IDLE, registered
//
// BEHAVIOUR
// - Reset: clk_i / arstn_i, reset asynchronous, active-low.
//   - All sync flops, counters, pattern register and outputs go to 0; state = IDLE.
//   - Reset mid-debounce or mid-hold aborts with no pulse.
// - Pattern: pat = {up_s, dwn_s}, taken from the last sync stage; pushed = |pat.
// - Counter widths: dbnc_cnt is $clog2(DEBOUNCE+1) bits; rpt_cnt is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) bits.
// - Counter overflow is impossible: both counters clear on hitting their terminal value.
// - FSM, 2 states:
//   - IDLE:
//     - If !pushed, or pat != pat_q: dbnc_cnt <= 0, and pat_q <= pat (restart on any pattern change).
//     - Else if dbnc_cnt == DEBOUNCE: go to HELD and clear dbnc_cnt.
//       - Press pulse on entry: pat 10 -> up_pulse_o = 1 for 1 cycle; pat 01 -> dwn_pulse_o = 1 for 1 cycle.
//       - pat 11 (both pressed): no pulse, but HELD is still entered.
//     - Else dbnc_cnt++.
//   - HELD:
//     - If pushed: dbnc_cnt <= 0 (any bounce restarts the release debounce).
//     - If !pushed: dbnc_cnt++; at dbnc_cnt == DEBOUNCE, go to IDLE and clear dbnc_cnt.
//     - Pulses are never emitted in HELD except auto-repeat (see CONFIGURATION).
// - Latency: raw edge held stable -> press pulse asserted NUM_SYNC+DEBOUNCE+1 clk_i edges later.
// - Pulse rules:
//   - Pulses are exactly 1 cycle wide.
//   - up_pulse_o and dwn_pulse_o are never high in the same cycle.
//   - There is never more than one press pulse per accepted press.
// - Release rule: a release shorter than DEBOUNCE cycles is ignored; it never produces a second press pulse.
//
// CONFIGURATION
// - Macro BTN_STEP_AUTOREPEAT_EN.
// - Defined: auto-repeat on a held single button.
//   - In HELD with pat == pat_q and pat in {10, 01}, rpt_cnt counts cycles.
//   - First repeat pulse when rpt_cnt reaches REPEAT_DELAY; further pulses every REPEAT_PERIOD cycles.
//   - rpt_cnt clears on entry to HELD, on any pattern change, when !pushed, and after each repeat pulse.
//   - Pattern 11 never repeats.
// - Undefined: rpt_cnt logic is absent; the REPEAT_* parameters are ignored; exactly one pulse per press.
//
// TESTING
// - Tests run with DEBOUNCE=4, NUM_SYNC=2.
// - Reset: assert arstn_i with up held -> all outputs 0. Release reset -> up_pulse_o fires 7 cycles after the first sampled edge.
// - Bounce: up toggles 1/0 every 2 cycles for 20 cycles, then stable 1 -> zero pulses during bouncing, exactly one up_pulse_o afterwards.
// - Release glitch: after up is accepted, drop up for 3 cycles then reassert, hold 20 cycles -> no second pulse; held_o stays 1.
// - Conflict: press up and dwn together -> no pulses and held_o = 1. Release both for >=5 stable cycles -> held_o = 0.
// - Pattern change: up stable 3 cycles, then dwn replaces it -> counter restarts; a single dwn_pulse_o and no up_pulse_o.
// - Repeat (_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3): hold dwn 30 cycles past acceptance -> pulses at +0, +10, +13, +16, ...; without _EN only the +0 pulse.

Source files
------------

// File: rtl/btn_step_ctrl.sv
// Frequency-step push-button conditioner: synchronise, debounce and reject conflicts on up/down.
// Define BTN_STEP_AUTOREPEAT_EN to add hold-to-repeat stepping on a single held button.
module btn_step_ctrl #(
  parameter int unsigned NUM_SYNC      = 2,
  parameter int unsigned DEBOUNCE      = 50000,
  parameter bit          BTN_ACTIVE    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic up_btn_i,
  input  logic dwn_btn_i,
  output logic up_pulse_o,
  output logic dwn_pulse_o,
  output logic held_o
);

  localparam int unsigned DbncW = $clog2(DEBOUNCE + 1);
  localparam logic [DbncW-1:0] DbncMax = DbncW'(DEBOUNCE);

  if (NUM_SYNC < 2) begin : g_bad_num_sync
    $error("NUM_SYNC must be at least 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("DEBOUNCE must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  typedef enum logic {StIdle, StHeld} state_e;

  // Polarity is normalised before the synchroniser so everything downstream is active-high.
  logic                up_raw, dwn_raw;
  logic [NUM_SYNC-1:0] up_sync, dwn_sync;

  assign up_raw  = BTN_ACTIVE ? up_btn_i  : ~up_btn_i;
  assign dwn_raw = BTN_ACTIVE ? dwn_btn_i : ~dwn_btn_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      up_sync  <= '0;
      dwn_sync <= '0;
    end else begin
      up_sync  <= {up_sync[NUM_SYNC-2:0], up_raw};
      dwn_sync <= {dwn_sync[NUM_SYNC-2:0], dwn_raw};
    end
  end

  logic [1:0]       pat;
  logic [1:0]       pat_q;
  logic             pushed;
  state_e           state;
  logic [DbncW-1:0] dbnc_cnt;
  logic             up_pulse, dwn_pulse, held;

  assign pat    = {up_sync[NUM_SYNC-1], dwn_sync[NUM_SYNC-1]};
  assign pushed = |pat;

`ifdef BTN_STEP_AUTOREPEAT_EN
  localparam int unsigned RptMaxVal = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
  localparam int unsigned RptW = $clog2(RptMaxVal + 1);
  localparam logic [RptW-1:0] RptDelay  = RptW'(REPEAT_DELAY);
  localparam logic [RptW-1:0] RptPeriod = RptW'(REPEAT_PERIOD);

  logic [RptW-1:0] rpt_cnt, rpt_next, rpt_target;
  logic            rpt_armed, rpt_run, rpt_hit;

  // Only a steady single-button pattern advances the repeat timer; 11 and 00 never do.
  assign rpt_run    = (pat == pat_q) && ((pat == 2'b10) || (pat == 2'b01));
  assign rpt_next   = rpt_cnt + RptW'(1);
  assign rpt_target = rpt_armed ? RptPeriod : RptDelay;
  assign rpt_hit    = rpt_run && (rpt_next == rpt_target);
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= StIdle;
      pat_q     <= '0;
      dbnc_cnt  <= '0;
      up_pulse  <= 1'b0;
      dwn_pulse <= 1'b0;
      held      <= 1'b0;
`ifdef BTN_STEP_AUTOREPEAT_EN
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
`endif
    end else begin
      up_pulse  <= 1'b0;
      dwn_pulse <= 1'b0;
      case (state)
        StIdle: begin
          if (!pushed || (pat != pat_q)) begin
            dbnc_cnt <= '0;
            pat_q    <= pat;
          end else if (dbnc_cnt == DbncMax) begin
            state     <= StHeld;
            held      <= 1'b1;
            dbnc_cnt  <= '0;
            up_pulse  <= (pat == 2'b10);
            dwn_pulse <= (pat == 2'b01);
`ifdef BTN_STEP_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
`endif
          end else begin
            dbnc_cnt <= dbnc_cnt + DbncW'(1);
          end
        end
        StHeld: begin
          pat_q <= pat;
          // Any sampled press restarts the release debounce.
          if (pushed) begin
            dbnc_cnt <= '0;
          end else if (dbnc_cnt == DbncMax) begin
            state    <= StIdle;
            held     <= 1'b0;
            dbnc_cnt <= '0;
          end else begin
            dbnc_cnt <= dbnc_cnt + DbncW'(1);
          end
`ifdef BTN_STEP_AUTOREPEAT_EN
          if (!rpt_run) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
          end else if (rpt_hit) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
            up_pulse  <= pat[1];
            dwn_pulse <= pat[0];
          end else begin
            rpt_cnt <= rpt_next;
          end
`endif
        end
        default: begin
          state <= StIdle;
          held  <= 1'b0;
        end
      endcase
    end
  end

  assign up_pulse_o  = up_pulse;
  assign dwn_pulse_o = dwn_pulse;
  assign held_o      = held;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Scoreboard bench for btn_step_ctrl: expected pulses are queued with the stimulus and
// matched (cycle and direction) by a monitor whenever the DUT emits a pulse.
module tb_btn_step_ctrl;

  localparam int unsigned NumSync   = 2;
  localparam int unsigned Debounce  = 4;
  localparam int unsigned RptDelay  = 10;
  localparam int unsigned RptPeriod = 3;
  // Input driven at a falling edge -> pulse seen at the falling edge this many cycles later.
  localparam int unsigned Lat = NumSync + Debounce + 2;

  typedef struct packed {
    int unsigned cyc;
    logic        up;
  } ev_t;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic up_btn = 1'b0;
  logic dwn_btn = 1'b0;
  logic up_pulse_o, dwn_pulse_o, held_o;

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  ev_t exp_q[$];
  ev_t mon_ev;

  btn_step_ctrl #(
    .NUM_SYNC     (NumSync),
    .DEBOUNCE     (Debounce),
    .BTN_ACTIVE   (1'b1),
    .REPEAT_DELAY (RptDelay),
    .REPEAT_PERIOD(RptPeriod)
  ) dut (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .up_btn_i   (up_btn),
    .dwn_btn_i  (dwn_btn),
    .up_pulse_o (up_pulse_o),
    .dwn_pulse_o(dwn_pulse_o),
    .held_o     (held_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (up_pulse_o === 1'b1 || dwn_pulse_o === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL pulse_unexpected: cyc=%0d got up=%b dwn=%b, required no pulse",
                 cyc, up_pulse_o, dwn_pulse_o);
      end else begin
        mon_ev = exp_q.pop_front();
        if (cyc !== mon_ev.cyc || up_pulse_o !== mon_ev.up || dwn_pulse_o !== !mon_ev.up) begin
          n_miss++;
          $display("FAIL pulse_match: got cyc=%0d up=%b dwn=%b, required cyc=%0d up=%b dwn=%b",
                   cyc, up_pulse_o, dwn_pulse_o, mon_ev.cyc, mon_ev.up, !mon_ev.up);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    up_btn = 1'b1;
    tick(5);
    n_vec += 3;
    if (up_pulse_o !== 1'b0) begin
      n_miss++; $display("FAIL reset_up_pulse: got %b, required 0", up_pulse_o);
    end
    if (dwn_pulse_o !== 1'b0) begin
      n_miss++; $display("FAIL reset_dwn_pulse: got %b, required 0", dwn_pulse_o);
    end
    if (held_o !== 1'b0) begin
      n_miss++; $display("FAIL reset_held: got %b, required 0", held_o);
    end
    arstn = 1'b1;
    exp_q.push_back('{cyc: cyc + Lat, up: 1'b1});
    tick(12);
    n_vec++;
    if (held_o !== 1'b1) begin
      n_miss++; $display("FAIL reset_release_held: got %b, required 1", held_o);
    end
    // Reset in the middle of a hold: no pulse, held drops immediately.
    arstn = 1'b0;
    #1;
    n_vec++;
    if (held_o !== 1'b0) begin
      n_miss++; $display("FAIL reset_mid_hold: held got %b, required 0", held_o);
    end
    tick(1);
    up_btn = 1'b0;
    tick(3);
    arstn = 1'b1;
    // Reset in the middle of a press debounce: aborted, no pulse.
    tick(2);
    dwn_btn = 1'b1;
    tick(5);
    arstn = 1'b0;
    #1;
    n_vec++;
    if (dwn_pulse_o !== 1'b0 || held_o !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_mid_debounce: dwn=%b held=%b, required 0 0", dwn_pulse_o, held_o);
    end
    tick(2);
    dwn_btn = 1'b0;
    arstn = 1'b1;
    tick(12);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++; $display("FAIL reset_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      up_btn = ((i / 2) % 2 == 0);
      tick(1);
    end
    up_btn = 1'b1;
    exp_q.push_back('{cyc: cyc + Lat, up: 1'b1});
    tick(14);
    n_vec++;
    if (held_o !== 1'b1) begin
      n_miss++; $display("FAIL bounce_held: got %b, required 1", held_o);
    end
    up_btn = 1'b0;
    tick(12);
    n_vec += 2;
    if (held_o !== 1'b0) begin
      n_miss++; $display("FAIL bounce_release: held got %b, required 0", held_o);
    end
    if (exp_q.size() != 0) begin
      n_miss++; $display("FAIL bounce_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_release_glitch();
    int bad;
    up_btn = 1'b1;
    exp_q.push_back('{cyc: cyc + Lat, up: 1'b1});
    tick(12);
    up_btn = 1'b0;
    tick(3);
    up_btn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (held_o !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++; $display("FAIL glitch_held: held low in %0d cycles, required 0", bad);
    end
    up_btn = 1'b0;
    tick(12);
    n_vec += 2;
    if (held_o !== 1'b0) begin
      n_miss++; $display("FAIL glitch_release: held got %b, required 0", held_o);
    end
    if (exp_q.size() != 0) begin
      n_miss++; $display("FAIL glitch_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_conflict();
    up_btn = 1'b1;
    dwn_btn = 1'b1;
    tick(12);
    n_vec++;
    if (held_o !== 1'b1) begin
      n_miss++; $display("FAIL conflict_held: got %b, required 1", held_o);
    end
    up_btn = 1'b0;
    dwn_btn = 1'b0;
    // Four stable released cycles are not enough; the fifth releases.
    tick(NumSync + Debounce);
    n_vec++;
    if (held_o !== 1'b1) begin
      n_miss++; $display("FAIL conflict_release_early: held got %b, required 1", held_o);
    end
    tick(1);
    n_vec++;
    if (held_o !== 1'b0) begin
      n_miss++; $display("FAIL conflict_release: held got %b, required 0", held_o);
    end
    tick(5);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++; $display("FAIL conflict_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pattern_change();
    up_btn = 1'b1;
    tick(3);
    up_btn = 1'b0;
    dwn_btn = 1'b1;
    exp_q.push_back('{cyc: cyc + Lat, up: 1'b0});
    tick(14);
    n_vec++;
    if (held_o !== 1'b1) begin
      n_miss++; $display("FAIL patchg_held: got %b, required 1", held_o);
    end
    dwn_btn = 1'b0;
    tick(12);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++; $display("FAIL patchg_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_repeat();
    int unsigned p;
    dwn_btn = 1'b1;
    p = cyc + Lat;
    exp_q.push_back('{cyc: p, up: 1'b0});
`ifdef BTN_STEP_AUTOREPEAT_EN
    // The synchroniser keeps the held pattern visible NumSync cycles past the release.
    for (int t = RptDelay; t <= 30 + NumSync; t += RptPeriod) begin
      exp_q.push_back('{cyc: p + t, up: 1'b0});
    end
`endif
    tick(Lat + 30);
    n_vec++;
    if (held_o !== 1'b1) begin
      n_miss++; $display("FAIL repeat_held: got %b, required 1", held_o);
    end
    dwn_btn = 1'b0;
    tick(12);
    n_vec += 2;
    if (held_o !== 1'b0) begin
      n_miss++; $display("FAIL repeat_release: held got %b, required 0", held_o);
    end
    if (exp_q.size() != 0) begin
      n_miss++; $display("FAIL repeat_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_release_glitch();
    test_conflict();
    test_pattern_change();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
